// File: rtl/fpu_issue_if.sv
// Issue and writeback handshakes of the fpu_issue sequencer.
// master drives operations and consumes results; slave is the sequencer.
interface fpu_issue_if;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  in_funct3;
  logic [6:0]  in_funct7;
  logic [4:0]  in_rd;
  logic [31:0] in_x1;
  logic [31:0] in_x2;
  logic        out_valid;
  logic        out_ready;
  logic [4:0]  out_rd;
  logic [31:0] out_y;
  logic        out_illegal;

  modport master (
    output in_valid, in_funct3, in_funct7,
    output in_rd, in_x1, in_x2, out_ready,
    input  in_ready, out_valid, out_rd,
    input  out_y, out_illegal
  );

  modport slave (
    input  in_valid, in_funct3, in_funct7,
    input  in_rd, in_x1, in_x2, out_ready,
    output in_ready, out_valid, out_rd,
    output out_y, out_illegal
  );
endinterface

// File: rtl/fpu_issue.sv
// Issue/writeback sequencer in front of the combinational fpu.
// Holds operands for a per-opcode latency, then captures the result.
module fpu_issue #(
  parameter int LAT_SGNJ = 1,
  parameter int LAT_ADD  = 3,
  parameter int LAT_MUL  = 3,
  parameter int LAT_DIV  = 10
) (
  input  logic        clk,
  input  logic        rst,
  fpu_issue_if.slave  bus,
  output logic [2:0]  fpu_funct3,
  output logic [6:0]  fpu_funct7,
  output logic [31:0] fpu_x1,
  output logic [31:0] fpu_x2,
  input  logic [31:0] fpu_y,
  output logic        busy
);

  typedef enum logic [1:0] {
    IDLE,
    EXEC,
    DONE
  } state_t;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [3:0]  dec_cnt;
  logic        dec_ill;
  logic        ill_q;
  logic [4:0]  rd_q;
  logic        load;
  logic        finish;
  logic        in_ready_c;
  logic [4:0]  out_rd_q;
  logic [31:0] out_y_q;
  logic        out_ill_q;

  // Counter preload is LAT-1 so a LAT=1 op finishes on the next edge.
  always_comb begin
    dec_cnt = 4'd0;
    dec_ill = 1'b0;
    unique case (bus.in_funct7)
      7'h10:        dec_cnt = 4'(LAT_SGNJ - 1);
      7'h00, 7'h04: dec_cnt = 4'(LAT_ADD - 1);
      7'h08:        dec_cnt = 4'(LAT_MUL - 1);
      7'h0C, 7'h2C: dec_cnt = 4'(LAT_DIV - 1);
      default:      dec_ill = 1'b1;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    in_ready_c = 1'b0;
    load       = 1'b0;
    finish     = 1'b0;
    unique case (state_q)
      IDLE: begin
        in_ready_c = 1'b1;
        if (bus.in_valid) begin
          load    = 1'b1;
          cnt_d   = dec_cnt;
          state_d = EXEC;
        end
      end
      EXEC: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          finish  = 1'b1;
          state_d = DONE;
        end
      end
      DONE: begin
        in_ready_c = bus.out_ready;
        if (bus.out_ready) begin
          if (bus.in_valid) begin
            load    = 1'b1;
            cnt_d   = dec_cnt;
            state_d = EXEC;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= 4'd0;
      ill_q      <= 1'b0;
      rd_q       <= 5'd0;
      fpu_funct3 <= 3'd0;
      fpu_funct7 <= 7'd0;
      fpu_x1     <= 32'd0;
      fpu_x2     <= 32'd0;
      out_rd_q   <= 5'd0;
      out_y_q    <= 32'd0;
      out_ill_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (load) begin
        ill_q      <= dec_ill;
        rd_q       <= bus.in_rd;
        fpu_funct3 <= bus.in_funct3;
        fpu_funct7 <= bus.in_funct7;
        fpu_x1     <= bus.in_x1;
        fpu_x2     <= bus.in_x2;
      end
      if (finish) begin
        out_rd_q  <= rd_q;
        out_y_q   <= fpu_y;
        out_ill_q <= ill_q;
      end
    end
  end

  assign bus.in_ready    = in_ready_c;
  assign bus.out_valid   = (state_q == DONE);
  assign bus.out_rd      = out_rd_q;
  assign bus.out_y       = out_y_q;
  assign bus.out_illegal = out_ill_q;
  assign busy            = (state_q != IDLE);

endmodule
